// File: rtl/imm_decode_pkg.sv
// imm_decode_pkg: LEGv8 immediate format codes and opcode constants
package imm_decode_pkg;
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_D    = 3'd2,
    FMT_IW   = 3'd3,
    FMT_CB   = 3'd4,
    FMT_B    = 3'd5
  } imm_fmt_t;
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [8:0]  OP_MOVZ  = 9'b110100101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;
endpackage

// File: rtl/imm_extract.sv
// imm_extract: classify a LEGv8 instruction and produce its extended, scaled 64-bit immediate
module imm_extract
  import imm_decode_pkg::*;
#(
  parameter int BR_SHIFT = 2
) (
  input  logic [31:0] instr,
  output imm_fmt_t    fmt,
  output logic [63:0] imm
);
  function automatic logic [63:0] ext(input logic [63:0] raw, input int unsigned w, input logic sgn);
    logic [63:0] mask;
    logic        msb;
    mask = (64'd1 << w) - 64'd1;
    msb  = |(raw & (64'd1 << (w - 1)));
    return (raw & mask) | ((sgn && msb) ? ~mask : 64'd0);
  endfunction
  // first matching format wins; shifts act on the already-extended 64-bit value
  always_comb begin
    fmt = FMT_NONE;
    imm = '0;
    if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) begin
      fmt = FMT_I;
      imm = ext(64'(instr[21:10]), 12, 1'b0);
    end else if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
      fmt = FMT_D;
      imm = ext(64'(instr[20:12]), 9, 1'b1);
    end else if (instr[31:23] == OP_MOVZ) begin
      fmt = FMT_IW;
      imm = ext(64'(instr[20:5]), 16, 1'b0) << {instr[22:21], 4'b0000};
    end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ || instr[31:24] == OP_BCOND) begin
      fmt = FMT_CB;
      imm = ext(64'(instr[23:5]), 19, 1'b1) << BR_SHIFT;
    end else if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
      fmt = FMT_B;
      imm = ext(64'(instr[25:0]), 26, 1'b1) << BR_SHIFT;
    end
  end
endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: one-entry valid/ready immediate decode register; IMM_DECODE_ILLEGAL_EN adds illegal_out
module imm_decode_stage
  import imm_decode_pkg::*;
#(
  parameter int BR_SHIFT = 2,
  parameter int ADDR_W   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] imm_out,
  output imm_fmt_t          fmt_out,
  output logic [4:0]        rd_out,
  output logic [ADDR_W-1:0] pc_out
`ifdef IMM_DECODE_ILLEGAL_EN
  ,
  output logic              illegal_out
`endif
);
  imm_fmt_t          w_fmt;
  logic [63:0]       w_imm;
  logic              w_load;
  logic              r_valid;
  logic [ADDR_W-1:0] r_imm;
  imm_fmt_t          r_fmt;
  logic [4:0]        r_rd;
  logic [ADDR_W-1:0] r_pc;
  imm_extract #(.BR_SHIFT(BR_SHIFT)) u_extract (
    .instr(instr_in),
    .fmt  (w_fmt),
    .imm  (w_imm)
  );
  assign in_ready  = !r_valid | out_ready | flush;
  assign w_load    = in_valid & in_ready;
  assign out_valid = r_valid;
  assign imm_out   = r_imm;
  assign fmt_out   = r_fmt;
  assign rd_out    = r_rd;
  assign pc_out    = r_pc;
  // flush squashes the entry; otherwise a load refills it and a drain empties it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_imm   <= '0;
      r_fmt   <= FMT_NONE;
      r_rd    <= '0;
      r_pc    <= '0;
    end else begin
      r_valid <= !flush & (w_load | (r_valid & !out_ready));
      if (w_load) begin
        r_imm <= w_imm[ADDR_W-1:0];
        r_fmt <= w_fmt;
        r_rd  <= instr_in[4:0];
        r_pc  <= pc_in;
      end
    end
  end
`ifdef IMM_DECODE_ILLEGAL_EN
  // unmatched-instruction flag, loaded alongside the format code
  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_out <= 1'b0;
    else if (w_load) illegal_out <= (w_fmt == FMT_NONE);
  end
`endif
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: randomized and directed check of imm_decode_stage against a behavioural model
module tb_imm_decode_stage;
  import imm_decode_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr_in = '0;
  logic [63:0] pc_in = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] imm_out;
  imm_fmt_t    fmt_out;
  logic [4:0]  rd_out;
  logic [63:0] pc_out;
`ifdef IMM_DECODE_ILLEGAL_EN
  logic        illegal_out;
`endif
  int checks = 0;
  int failures = 0;

  imm_decode_stage #(.BR_SHIFT(2), .ADDR_W(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .imm_out(imm_out), .fmt_out(fmt_out), .rd_out(rd_out),
    .pc_out(pc_out)
`ifdef IMM_DECODE_ILLEGAL_EN
    , .illegal_out(illegal_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // reference decode using signed integer arithmetic
  function automatic void ref_dec(input logic [31:0] ins, output logic [2:0] f, output logic [63:0] imm);
    longint s;
    f = 3'd0;
    imm = 64'd0;
    if (ins[31:22] == 10'b1001000100 || ins[31:22] == 10'b1101000100) begin
      f = 3'd1; imm = 64'(ins[21:10]);
    end else if (ins[31:21] == 11'b11111000010 || ins[31:21] == 11'b11111000000) begin
      f = 3'd2; s = $signed(ins[20:12]); imm = s;
    end else if (ins[31:23] == 9'b110100101) begin
      f = 3'd3; imm = 64'(ins[20:5]) * (64'd65536 ** ins[22:21]);
    end else if (ins[31:24] == 8'b10110100 || ins[31:24] == 8'b10110101 || ins[31:24] == 8'b01010100) begin
      f = 3'd4; s = $signed(ins[23:5]); imm = s * 4;
    end else if (ins[31:26] == 6'b000101 || ins[31:26] == 6'b100101) begin
      f = 3'd5; s = $signed(ins[25:0]); imm = s * 4;
    end
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 2);
    case ($urandom_range(0, 6))
      0: return {(k == 0 ? OP_ADDI : OP_SUBI), r[21:0]};
      1: return {(k == 0 ? OP_LDUR : OP_STUR), r[20:0]};
      2: return {OP_MOVZ, r[22:0]};
      3: return {(k == 0 ? OP_CBZ : k == 1 ? OP_CBNZ : OP_BCOND), r[23:0]};
      4: return {(k == 0 ? OP_B : OP_BL), r[25:0]};
      default: return r;
    endcase
  endfunction

  // behavioural one-entry pipeline model
  logic        m_valid;
  logic [63:0] m_imm, m_pc, t_imm;
  logic [2:0]  m_fmt, t_fmt;
  logic [4:0]  m_rd;
  logic        m_ill;
  logic        m_acc;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
    end else begin
      m_acc = in_valid && (!m_valid || out_ready || flush);
      if (m_acc) begin
        ref_dec(instr_in, t_fmt, t_imm);
        m_imm <= t_imm;
        m_fmt <= t_fmt;
        m_ill <= (t_fmt == 3'd0);
        m_rd  <= instr_in[4:0];
        m_pc  <= pc_in;
      end
      if (flush) m_valid <= 1'b0;
      else if (m_acc) m_valid <= 1'b1;
      else if (out_ready) m_valid <= 1'b0;
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready || flush));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("imm", imm_out, m_imm);
        chk("fmt", 64'(fmt_out), 64'(m_fmt));
        chk("rd", 64'(rd_out), 64'(m_rd));
        chk("pc", pc_out, m_pc);
`ifdef IMM_DECODE_ILLEGAL_EN
        chk("illegal", 64'(illegal_out), 64'(m_ill));
`endif
      end
    end
  end

  task automatic set_in(input logic v, input logic [31:0] ins, input logic [63:0] pc, input logic rdy, input logic fl);
    in_valid = v; instr_in = ins; pc_in = pc; out_ready = rdy; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_imm"}, imm_out, 64'd0);
    chk({tag, "_fmt"}, 64'(fmt_out), 64'd0);
    chk({tag, "_rd"}, 64'(rd_out), 64'd0);
    chk({tag, "_pc"}, pc_out, 64'd0);
`ifdef IMM_DECODE_ILLEGAL_EN
    chk({tag, "_illegal"}, 64'(illegal_out), 64'd0);
`endif
  endtask

  logic [31:0] i_addi, i_ldur, i_movz, i_b, i_cbz;

  initial begin
    i_addi = {10'b1001000100, 12'hFFF, 5'd0, 5'd1};
    i_ldur = {11'b11111000010, 9'h1F0, 2'b00, 5'd0, 5'd2};
    i_movz = {9'b110100101, 2'd2, 16'hBEEF, 5'd3};
    i_b    = {6'b000101, 26'h3FFFFFF};
    i_cbz  = {8'b10110100, 19'h10, 5'd4};
    #1 reset = 1'b1;
    #1 chk_reset_vals("rst0");
    tick();
    reset = 1'b0;
    set_in(1, i_addi, 64'h40, 1, 0); tick();
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_fmt", 64'(fmt_out), 64'(FMT_I));
    chk("addi_imm", imm_out, 64'h0000_0000_0000_0FFF);
    chk("addi_rd", 64'(rd_out), 64'd1);
    chk("addi_pc", pc_out, 64'h40);
    set_in(1, i_ldur, 64'h44, 1, 0); tick();
    chk("ldur_imm", imm_out, 64'hFFFF_FFFF_FFFF_FFF0);
    chk("ldur_fmt", 64'(fmt_out), 64'(FMT_D));
    set_in(1, i_movz, 64'h48, 1, 0); tick();
    chk("movz_imm", imm_out, 64'h0000_BEEF_0000_0000);
    set_in(1, i_b, 64'h4C, 1, 0); tick();
    chk("b_imm", imm_out, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("b_fmt", 64'(fmt_out), 64'(FMT_B));
    set_in(1, i_cbz, 64'h50, 1, 0); tick();
    chk("cbz_imm", imm_out, 64'h40);
    set_in(1, i_addi, 64'h54, 0, 0);
    for (int n = 0; n < 3; n++) begin
      #1 chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_fmt", 64'(fmt_out), 64'(FMT_CB));
      chk("stall_pc", pc_out, 64'h50);
      tick();
    end
    chk("stall_hold_valid", 64'(out_valid), 64'd1);
    chk("stall_hold_fmt", 64'(fmt_out), 64'(FMT_CB));
    out_ready = 1'b1;
    #1 chk("release_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("nobubble_valid", 64'(out_valid), 64'd1);
    chk("nobubble_fmt", 64'(fmt_out), 64'(FMT_I));
    chk("nobubble_pc", pc_out, 64'h54);
    set_in(1, i_movz, 64'h58, 0, 0); tick();
    set_in(1, i_ldur, 64'h5C, 0, 1);
    #1 chk("flush_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("flush_valid", 64'(out_valid), 64'd0);
    set_in(1, 32'h0000_0000, 64'h60, 0, 0); tick();
    chk("none_fmt", 64'(fmt_out), 64'(FMT_NONE));
    chk("none_imm", imm_out, 64'd0);
`ifdef IMM_DECODE_ILLEGAL_EN
    chk("none_illegal", 64'(illegal_out), 64'd1);
`endif
    set_in(1, i_b, 64'h64, 1, 0); tick();
    set_in(1, i_cbz, 64'h68, 0, 0); tick();
    #1 reset = 1'b1;
    #1 chk_reset_vals("rst_mid");
    tick();
    set_in(0, '0, '0, 0, 0);
    reset = 1'b0;
    tick();
    for (int n = 0; n < 1500; n++) begin
      set_in($urandom_range(0, 3) != 0, rnd_instr(), {$urandom, $urandom},
             $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
      tick();
    end
    set_in(0, '0, '0, 1, 0);
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Decode-side immediate stage of the pipelined LEGv8 core, sitting between the IF/ID register and the ID/EX register.
- Classifies the fetched 32-bit instruction by format and extracts its immediate field. It then sign- or zero-extends the field to 64 bits and scales branch offsets.
- Presents the registered result, with PC and destination register, to the execute stage.
- Uses a one-entry valid/ready pipeline register with stall and flush.

Parameters:
- BR_SHIFT, 2: left shift applied to B/CB offsets (word offset to byte offset).
- ADDR_W, 64: PC and immediate output width.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  upstream holds a valid instruction.
- in_ready  output  1  stage can accept this cycle.
- instr_in  input  32  raw instruction word.
- pc_in  input  ADDR_W  PC of instr_in.
- flush  input  1  synchronous squash (branch mispredict).
- out_valid  output  1  registered result valid.
- out_ready  input  1  downstream accepts this cycle.
- imm_out  output  ADDR_W  extended/scaled immediate.
- fmt_out  output  3  format code (imm_fmt_t).
- rd_out  output  5  instr[4:0].
- pc_out  output  ADDR_W  registered pc_in.

Behaviour:
- Reset (asynchronous, any time): out_valid=0, imm_out=0, fmt_out=FMT_NONE, rd_out=0, pc_out=0.
- Reset mid-stall discards the held entry.
- Handshake: in_ready = !out_valid | out_ready | flush. A transfer occurs when in_valid & in_ready.
- Latency: exactly 1 cycle from accept to out_valid.
- Registered fields change only on a load.
- Stall: while out_valid & !out_ready & !flush, all outputs hold stable.
- Flush has priority: next edge out_valid=0.
- A concurrent in_valid instruction is consumed and discarded, since in_ready=1.
- Data registers may load but are don't-care.
- No flush, out_valid & out_ready & in_valid: the new entry replaces the old with no bubble.
- Without a new input, out_valid drops to 0.
- Decode priority, first match wins:
  - ADDI/SUBI, [31:22]=1001000100/1101000100: FMT_I, zero-extend [21:10].
  - LDUR/STUR, [31:21]=11111000010/11111000000: FMT_D, sign-extend [20:12].
  - MOVZ, [31:23]=110100101: FMT_IW, zero-extend [20:5] shifted left by 16*[22:21].
  - CBZ/CBNZ/B.cond, [31:24]=10110100/10110101/01010100: FMT_CB, sign-extend [23:5] << BR_SHIFT.
  - B/BL, [31:26]=000101/100101: FMT_B, sign-extend [25:0] << BR_SHIFT.
  - Otherwise: FMT_NONE, imm=0.
- Arithmetic: the shift is on the 64-bit value after extension; bits shifted past bit 63 are dropped.
- The extend step is a combinational sub-function feeding the register.

Optional Feature:
- Macro IMM_DECODE_ILLEGAL_EN.
- When defined, adds output illegal_out (1 bit), registered alongside fmt_out.
  - It is 1 when the accepted instruction matched no format.
  - Reset value 0; it holds during stall and is qualified by out_valid.
- Without the macro, the port does not exist and unmatched instructions only produce FMT_NONE/imm 0.

Decomposition:
- Package imm_decode_pkg: imm_fmt_t enum (FMT_NONE, FMT_I, FMT_D, FMT_IW, FMT_CB, FMT_B) and the opcode constants for each format.
- Sub-module: imm_extract, combinational.
  - Inputs: instr, BR_SHIFT.
  - Outputs: fmt and 64-bit imm.
  - Contains the width-generic sign/zero-extension.
- The top level holds only the handshake and pipeline register.

Test Plan:
- ADDI, imm12=0xFFF, Rd=1, pc=0x40, out_ready=1: next cycle out_valid=1, fmt=FMT_I, imm=0x0000_0000_0000_0FFF, rd=1, pc_out=0x40.
- LDUR, imm9=0x1F0: imm=0xFFFF_FFFF_FFFF_FFF0.
- MOVZ, hw=2, imm16=0xBEEF: imm=0x0000_BEEF_0000_0000.
- B, imm26=0x3FFFFFF: imm=0xFFFF_FFFF_FFFF_FFFC. CBZ, imm19=0x10: imm=0x40.
- Accept CBZ, hold out_ready=0 for 3 cycles while upstream offers ADDI:
  - in_ready=0 and outputs stay CBZ.
  - Raise out_ready: ADDI appears the next cycle with no bubble.
- Assert flush during a stall with in_valid=1:
  - in_ready=1 and out_valid=0 next cycle.
  - Assert reset mid-stream: outputs clear immediately, without waiting for a clock edge.
- With IMM_DECODE_ILLEGAL_EN, instr=0x0000_0000: fmt=FMT_NONE, imm=0, illegal_out=1.
